rr_arbiter_4: RTL

//  4-requester round-robin arbiter; drives the 2-bit select feeding the 2-to-4 one-hot decoder stage.

---
 rtl/rr_arbiter_4.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-requester round-robin arbiter with hold timeout and dead cycle
//
// Purpose: grants one of four level requesters at a time. The grant is a registered
// 2-bit index plus valid qualifier, held stable for the whole transaction. A grant is
// released on done, on requester withdrawal or on hold timeout. Every release passes
// through a one-cycle GAP, so downstream one-hot selects never overlap.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   4  level request, bit i = requester i
//   done       in   1  granted requester finished (only looked at while granted)
//   gnt_idx    out  2  index of granted requester, frozen while gnt_valid=1
//   gnt_valid  out  1  gnt_idx is a live grant
//   timeout    out  1  one-cycle pulse, grant revoked by the hold limit
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit TIMEOUT_EN = (HOLD_MAX != 0);
  // hold_cnt is 0 on the first granted cycle, so hitting HOLD_MAX-1 means the
  // grant has been visible for HOLD_MAX cycles once the release takes effect.
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  state_t           state, state_d;
  logic [1:0]       idx_d;
  logic             valid_d;
  logic             timeout_d;
  logic [1:0]       last_idx, last_d;
  logic [CNT_W-1:0] hold_cnt, cnt_d;
  logic [1:0]       winner;
  logic             found;

  // Scan starting just after the last served requester, so it gets lowest priority.
  always_comb begin
    winner = last_idx;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[last_idx + 2'(k)]) begin
        winner = last_idx + 2'(k);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    timeout_d = 1'b0;
    last_d    = last_idx;
    cnt_d     = hold_cnt;
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (found) begin
          state_d = GRANT;
          idx_d   = winner;
          valid_d = 1'b1;
          last_d  = winner;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (hold_cnt != '1) cnt_d = hold_cnt + 1'b1;
        // done outranks timeout, so a collision releases without a pulse.
        if (done || !req[gnt_idx]) begin
          state_d = GAP;
          valid_d = 1'b0;
        end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
          state_d   = GAP;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last_idx  <= 2'd3;
      hold_cnt  <= '0;
    end else begin
      state     <= state_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
      last_idx  <= last_d;
      hold_cnt  <= cnt_d;
    end
  end

endmodule
